// File: rtl/counter_stim_pkg.sv
// Shared types and constants for the counter stimulus generator and its reference model.
package counter_stim_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int ERR_CNT_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        UP,
        HOLD,
        DOWN,
        DONE
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/counter_ref_model.sv
// Shadow of the loadable up/down counter: tracks the expected count from the issued
// commands and flags a mismatch whenever checking is enabled.
module counter_ref_model
    import counter_stim_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_cnt_n_i,
    input  logic             updn_cnt_i,
    input  logic             count_enb_i,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic [WIDTH-1:0] data_out_i,
    input  logic             chk_en_i,
    output logic             mismatch_o
);

    logic [WIDTH-1:0] exp_q;

    // Same commands the real counter sees, so exp_q is what data_out should show.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q <= '0;
        end else if (!ld_cnt_n_i) begin
            exp_q <= data_in_i;
        end else if (count_enb_i) begin
            exp_q <= updn_cnt_i ? exp_q + 1'b1 : exp_q - 1'b1;
        end
    end

    assign mismatch_o = chk_en_i && (data_out_i != exp_q);

endmodule

// File: rtl/counter_stim_gen.sv
// Drives a LOAD/UP/HOLD/DOWN command sequence into a loadable counter and counts
// disagreements between its output and the reference model.
module counter_stim_gen
    import counter_stim_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] LOAD_VALUE  = WIDTH'(8'hF0),
    parameter int               UP_CYCLES   = 20,
    parameter int               HOLD_CYCLES = 4,
    parameter int               DOWN_CYCLES = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 ld_cnt_,
    output logic                 updn_cnt,
    output logic                 count_enb,
    output logic [WIDTH-1:0]     data_in,
    input  logic [WIDTH-1:0]     data_out,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int MAX_LEN = max3(UP_CYCLES, HOLD_CYCLES, DOWN_CYCLES);
    localparam int PH_W    = $clog2(MAX_LEN + 1);

    localparam logic [PH_W-1:0] UP_LAST   = PH_W'(UP_CYCLES - 1);
    localparam logic [PH_W-1:0] HOLD_LAST = PH_W'(HOLD_CYCLES - 1);
    localparam logic [PH_W-1:0] DOWN_LAST = PH_W'(DOWN_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [PH_W-1:0]        phase_q, phase_d;
    logic                   ld_n_q, updn_q, enb_q, busy_q, done_q;
    logic [WIDTH-1:0]       din_q;
    logic                   chk_en_q, err_q, mismatch;
    logic [ERR_CNT_W-1:0]   err_cnt_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                state_d = UP;
                phase_d = UP_LAST;
            end
            UP: begin
                if (phase_q == '0) begin
                    state_d = HOLD;
                    phase_d = HOLD_LAST;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            HOLD: begin
                if (phase_q == '0) begin
                    state_d = DOWN;
                    phase_d = DOWN_LAST;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            DOWN: begin
                if (phase_q == '0) state_d = DONE;
                else               phase_d = phase_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the next state so they are registered yet aligned with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            ld_n_q  <= 1'b1;
            updn_q  <= 1'b0;
            enb_q   <= 1'b0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ld_n_q  <= (state_d != LOAD);
            updn_q  <= (state_d == UP) || (state_d == HOLD);
            enb_q   <= (state_d == UP) || (state_d == DOWN);
            din_q   <= (state_d == LOAD) ? LOAD_VALUE : '0;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    // Checking starts once the loaded value is visible and ends with the DONE-cycle check.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_en_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            if (state_q == LOAD)      chk_en_q <= 1'b1;
            else if (state_q == DONE) chk_en_q <= 1'b0;
            err_q <= mismatch;
            if (state_q == IDLE && start)
                err_cnt_q <= '0;
            else if (mismatch && err_cnt_q != '1)
                err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    counter_ref_model #(
        .WIDTH(WIDTH)
    ) u_ref (
        .clk         (clk),
        .rst         (rst),
        .ld_cnt_n_i  (ld_n_q),
        .updn_cnt_i  (updn_q),
        .count_enb_i (enb_q),
        .data_in_i   (din_q),
        .data_out_i  (data_out),
        .chk_en_i    (chk_en_q),
        .mismatch_o  (mismatch)
    );

    assign ld_cnt_   = ld_n_q;
    assign updn_cnt  = updn_q;
    assign count_enb = enb_q;
    assign data_in   = din_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule
